chu_io_pwm_fade_core: RTL and testbench

MMIO slot core that generates `W` channels of glitch-free PWM for the RGB LEDs and similar loads, and ramps each channel toward a software-set target duty. It occupies one slot of the MMIO subsystem, is addressed through the standard slot bus behind the MicroBlaze MCS bridge, and its `pwm` vector is routed at top level to `rgb_led1`/`rgb_led2`.

---
 rtl/chu_io_pwm_fade_core.sv | 171 +++++++++++++++++
 tb/tb_chu_io_pwm_fade_core.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chu_io_pwm_fade_core.sv
// MMIO slot core: W channels of glitch-free PWM, each ramping its current duty toward a software target.
// Optional build macro PWM_FADE_EN adds the fade engine (FADE register, step counter); without it duties load at each period boundary.
module chu_io_pwm_fade_core #(
    parameter int W = 8,
    parameter int R = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cs,
    input  logic         read,
    input  logic         write,
    input  logic [4:0]   addr,
    input  logic [31:0]  wr_data,
    output logic [31:0]  rd_data,
    output logic [W-1:0] pwm
);
    localparam int IW = (W > 1) ? $clog2(W) : 1;
    localparam logic [R:0] DUTY_MAX = {1'b1, {R{1'b0}}};

    logic        wr_en;
    logic        rd_en;
    logic        wr_dvsr;
    logic        wr_ctrl;
    logic        wr_duty;
    logic        ctrl_off;
    logic [3:0]  duty_idx;
    logic [R:0]  duty_clamped;

    logic [31:0]  dvsr_reg;
    logic [31:0]  q_reg;
    logic         en_reg;
    logic [R-1:0] d_reg;
    logic         tick;
    logic         pb;
    logic         load_now;
    logic         step_now;

    logic [W-1:0] busy;
    logic [R:0]   cur_arr [W];

    assign wr_en    = cs & write;
    assign rd_en    = cs & read;
    assign wr_dvsr  = wr_en && (addr == 5'd0);
    assign wr_ctrl  = wr_en && (addr == 5'd1);
    assign wr_duty  = wr_en && addr[4];
    assign duty_idx = addr[3:0];
    // Disabling must silence pwm on the very next cycle, not one later.
    assign ctrl_off = wr_ctrl && !wr_data[0];

    assign duty_clamped = (wr_data > 32'(DUTY_MAX)) ? DUTY_MAX : wr_data[R:0];

    assign tick = en_reg && (q_reg == dvsr_reg);
    assign pb   = tick && (d_reg == '1);

    // Prescaler, period counter and control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            dvsr_reg <= '0;
            en_reg   <= 1'b0;
            q_reg    <= '0;
            d_reg    <= '0;
        end else begin
            if (wr_dvsr)
                dvsr_reg <= wr_data;
            if (wr_ctrl)
                en_reg <= wr_data[0];

            if (!en_reg || wr_dvsr || tick)
                q_reg <= '0;
            else
                q_reg <= q_reg + 32'd1;

            if (!en_reg)
                d_reg <= '0;
            else if (tick)
                d_reg <= d_reg + 1'b1;
        end
    end

`ifdef PWM_FADE_EN
    logic        wr_fade;
    logic        fade_due;
    logic [15:0] fade_reg;
    logic [15:0] s_reg;

    assign wr_fade  = wr_en && (addr == 5'd2);
    assign fade_due = (s_reg == fade_reg - 16'd1);
    assign load_now = pb && (fade_reg == 16'd0);
    assign step_now = pb && (fade_reg != 16'd0) && fade_due;

    // Step counter: counts period boundaries between one-LSB fade steps
    always_ff @(posedge clk) begin
        if (reset) begin
            fade_reg <= '0;
            s_reg    <= '0;
        end else begin
            if (wr_fade)
                fade_reg <= wr_data[15:0];
            if (wr_fade)
                s_reg <= '0;
            else if (pb && (fade_reg != 16'd0))
                s_reg <= fade_due ? 16'd0 : s_reg + 16'd1;
        end
    end
`else
    assign load_now = pb;
    assign step_now = 1'b0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_ch
            logic [R:0] tgt_reg;
            logic [R:0] cur_reg;
            logic       pwm_reg;
            logic       wr_this;

            assign wr_this = wr_duty && ({1'b0, duty_idx} == 5'(gi));

            // cur only moves at a period boundary, so a period is never cut short
            always_ff @(posedge clk) begin
                if (reset) begin
                    tgt_reg <= '0;
                    cur_reg <= '0;
                    pwm_reg <= 1'b0;
                end else begin
                    if (wr_this)
                        tgt_reg <= duty_clamped;

                    if (load_now)
                        cur_reg <= tgt_reg;
                    else if (step_now) begin
                        if (cur_reg < tgt_reg)
                            cur_reg <= cur_reg + 1'b1;
                        else if (cur_reg > tgt_reg)
                            cur_reg <= cur_reg - 1'b1;
                    end

                    if (en_reg && !ctrl_off)
                        pwm_reg <= (cur_reg > {1'b0, d_reg});
                    else
                        pwm_reg <= 1'b0;
                end
            end

            assign busy[gi]    = (cur_reg != tgt_reg);
            assign cur_arr[gi] = cur_reg;
            assign pwm[gi]     = pwm_reg;
        end
    endgenerate

    // Zero-wait-state read mux
    always_comb begin
        rd_data = '0;
        if (rd_en) begin
            case (addr)
                5'd0: rd_data = dvsr_reg;
                5'd1: rd_data[0] = en_reg;
`ifdef PWM_FADE_EN
                5'd2: rd_data[15:0] = fade_reg;
`endif
                5'd3: rd_data[W-1:0] = busy;
                default: begin
                    if (addr[4] && ({1'b0, duty_idx} < 5'(W)))
                        rd_data[R:0] = cur_arr[duty_idx[IW-1:0]];
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chu_io_pwm_fade_core.sv
// Directed self-checking bench for chu_io_pwm_fade_core (W=8, R=10); fade checks build only with PWM_FADE_EN.
module tb_chu_io_pwm_fade_core;
    localparam int W = 8;
    localparam int R = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         cs;
    logic         read;
    logic         write;
    logic [4:0]   addr;
    logic [31:0]  wr_data;
    logic [31:0]  rd_data;
    logic [W-1:0] pwm;

    int n_cmp = 0;
    int n_bad = 0;

    chu_io_pwm_fade_core #(.W(W), .R(R)) dut (
        .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .pwm(pwm)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        @(negedge clk);
        cs = 1'b0; write = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; read = 1'b1; addr = a;
        #1;
        d = rd_data;
        cs = 1'b0; read = 1'b0;
    endtask

    // Returns at the first negedge where pwm[ch] is seen high after being low.
    task automatic wait_rise(input int ch, input int limit, output bit ok);
        bit seen_low;
        ok = 1'b0;
        seen_low = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (!pwm[ch])
                seen_low = 1'b1;
            else if (seen_low) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset;
        logic [31:0] v;
        logic [4:0] al [5] = '{5'd0, 5'd1, 5'd3, 5'h10, 5'h17};
        n_cmp++;
        if (pwm !== '0) begin
            n_bad++; $display("FAIL reset_pwm: got %h expected 0", pwm);
        end
        for (int i = 0; i < 5; i++) begin
            rd(al[i], v);
            n_cmp++;
            if (v !== 32'd0) begin
                n_bad++; $display("FAIL reset_reg[%0d]: got %0d expected 0", al[i], v);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_basic;
        logic [31:0] v;
        bit ok;
        int hi;
        logic [W-1:0] others;
        wr(5'd0, 32'd0);
        wr(5'h10, 32'd512);
        rd(5'd3, v);
        n_cmp++;
        if (v !== 32'h1) begin
            n_bad++; $display("FAIL basic_busy: got %h expected 1", v);
        end
        wr(5'd1, 32'd1);
        wait_rise(0, 3000, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++; $display("FAIL basic_rise_timeout: got 0 expected 1");
        end
        hi = 0;
        others = '0;
        for (int k = 0; k < 1024; k++) begin
            if (k > 0) @(negedge clk);
            hi += int'(pwm[0]);
            others |= {pwm[W-1:1], 1'b0};
        end
        n_cmp++;
        if (hi != 512) begin
            n_bad++; $display("FAIL basic_high_count: got %0d expected 512", hi);
        end
        n_cmp++;
        if (others !== '0) begin
            n_bad++; $display("FAIL basic_other_ch: got %h expected 0", others);
        end
        rd(5'd3, v);
        n_cmp++;
        if (v !== 32'd0) begin
            n_bad++; $display("FAIL basic_status: got %h expected 0", v);
        end
        rd(5'h10, v);
        n_cmp++;
        if (v !== 32'd512) begin
            n_bad++; $display("FAIL basic_readback: got %0d expected 512", v);
        end
        $display("test_basic done high=%0d", hi);
    endtask

    task automatic test_extremes;
        logic [31:0] v;
        bit ok1, ok2;
        int c1, c2, c3;
        wr(5'h11, 32'd0);
        wr(5'h12, 32'd1024);
        wr(5'h13, 32'd2000);
        wait_rise(0, 3000, ok1);
        wait_rise(0, 3000, ok2);
        n_cmp++;
        if (!(ok1 && ok2)) begin
            n_bad++; $display("FAIL ext_rise_timeout: got 0 expected 1");
        end
        c1 = 0; c2 = 0; c3 = 0;
        for (int k = 0; k < 1024; k++) begin
            @(negedge clk);
            c1 += int'(pwm[1]);
            c2 += int'(pwm[2]);
            c3 += int'(pwm[3]);
        end
        n_cmp++;
        if (c1 != 0) begin
            n_bad++; $display("FAIL ext_duty0: got %0d expected 0", c1);
        end
        n_cmp++;
        if (c2 != 1024) begin
            n_bad++; $display("FAIL ext_duty1024: got %0d expected 1024", c2);
        end
        n_cmp++;
        if (c3 != 1024) begin
            n_bad++; $display("FAIL ext_clamp_pwm: got %0d expected 1024", c3);
        end
        rd(5'h13, v);
        n_cmp++;
        if (v !== 32'd1024) begin
            n_bad++; $display("FAIL ext_clamp_read: got %0d expected 1024", v);
        end
        $display("test_extremes done %0d %0d %0d", c1, c2, c3);
    endtask

    task automatic test_midperiod;
        bit ok1, ok2;
        int hi1, hi2, rises;
        logic prev;
        wr(5'd0, 32'd3);
        wr(5'h10, 32'd256);
        wait_rise(0, 10000, ok1);
        wait_rise(0, 10000, ok2);
        n_cmp++;
        if (!(ok1 && ok2)) begin
            n_bad++; $display("FAIL mid_rise_timeout: got 0 expected 1");
        end
        hi1 = 0; hi2 = 0; rises = 0; prev = 1'b1;
        for (int k = 0; k < 8192; k++) begin
            if (k > 0) @(negedge clk);
            if (k < 4096) hi1 += int'(pwm[0]);
            else hi2 += int'(pwm[0]);
            if (k > 0 && !prev && pwm[0]) rises++;
            prev = pwm[0];
            if (k == 100) begin
                cs = 1'b1; write = 1'b1; addr = 5'h10; wr_data = 32'd768;
            end else if (k == 101) begin
                cs = 1'b0; write = 1'b0;
            end
        end
        n_cmp++;
        if (hi1 != 1024) begin
            n_bad++; $display("FAIL mid_period1_high: got %0d expected 1024", hi1);
        end
        n_cmp++;
        if (hi2 != 3072) begin
            n_bad++; $display("FAIL mid_period2_high: got %0d expected 3072", hi2);
        end
        n_cmp++;
        if (rises != 1) begin
            n_bad++; $display("FAIL mid_runt_rises: got %0d expected 1", rises);
        end
        $display("test_midperiod done %0d %0d rises=%0d", hi1, hi2, rises);
    endtask

`ifdef PWM_FADE_EN
    task automatic test_fade;
        logic [31:0] v, st;
        bit ok;
        int exp_up [8] = '{0, 1, 1, 2, 2, 3, 3, 4};
        int exp_rd [7] = '{0, 1, 1, 2, 2, 1, 1};
        wr(5'd0, 32'd0);
        wait_rise(0, 6000, ok);
        wr(5'd2, 32'd2);
        wr(5'h14, 32'd4);
        rd(5'd2, v);
        n_cmp++;
        if (v !== 32'd2) begin
            n_bad++; $display("FAIL fade_reg_read: got %0d expected 2", v);
        end
        for (int k = 1; k <= 8; k++) begin
            wait_rise(0, 2000, ok);
            rd(5'h14, v);
            rd(5'd3, st);
            n_cmp++;
            if (!ok || v !== 32'(exp_up[k-1]) || st[4] !== (k < 8)) begin
                n_bad++;
                $display("FAIL fade_up[%0d]: got cur=%0d busy=%0b expected cur=%0d busy=%0b",
                         k, v, st[4], exp_up[k-1], (k < 8));
            end
        end
        wr(5'd2, 32'd0);
        wr(5'h14, 32'd0);
        wait_rise(0, 2000, ok);
        wait_rise(0, 2000, ok);
        wr(5'd2, 32'd2);
        wr(5'h14, 32'd4);
        for (int k = 1; k <= 7; k++) begin
            wait_rise(0, 2000, ok);
            rd(5'h14, v);
            n_cmp++;
            if (!ok || v !== 32'(exp_rd[k-1])) begin
                n_bad++; $display("FAIL fade_redirect[%0d]: got %0d expected %0d", k, v, exp_rd[k-1]);
            end
            if (k == 4) wr(5'h14, 32'd1);
        end
        $display("test_fade done");
    endtask
`endif

    task automatic test_boundary_update;
        logic [31:0] v;
        bit ok;
        wr(5'd0, 32'd0);
        wr(5'd2, 32'd0);
`ifndef PWM_FADE_EN
        wr(5'd2, 32'd5);
        rd(5'd2, v);
        n_cmp++;
        if (v !== 32'd0) begin
            n_bad++; $display("FAIL nofade_addr2: got %0d expected 0", v);
        end
`endif
        wait_rise(0, 6000, ok);
        wr(5'h15, 32'd7);
        rd(5'h15, v);
        n_cmp++;
        if (v !== 32'd0) begin
            n_bad++; $display("FAIL bnd_before: got %0d expected 0", v);
        end
        rd(5'd3, v);
        n_cmp++;
        if (v[5] !== 1'b1) begin
            n_bad++; $display("FAIL bnd_busy: got %0b expected 1", v[5]);
        end
        wait_rise(0, 2000, ok);
        rd(5'h15, v);
        n_cmp++;
        if (!ok || v !== 32'd7) begin
            n_bad++; $display("FAIL bnd_after: got %0d expected 7", v);
        end
        rd(5'd3, v);
        n_cmp++;
        if (v[5] !== 1'b0) begin
            n_bad++; $display("FAIL bnd_idle: got %0b expected 0", v[5]);
        end
        $display("test_boundary_update done");
    endtask

    task automatic test_disable;
        logic [31:0] v;
        int run;
        @(negedge clk);
        n_cmp++;
        if (pwm[2] !== 1'b1) begin
            n_bad++; $display("FAIL dis_pre: got %0b expected 1", pwm[2]);
        end
        cs = 1'b1; write = 1'b1; addr = 5'd1; wr_data = 32'd0;
        @(negedge clk);
        cs = 1'b0; write = 1'b0;
        n_cmp++;
        if (pwm !== '0) begin
            n_bad++; $display("FAIL dis_next_cycle: got %h expected 0", pwm);
        end
        repeat (50) @(negedge clk);
        n_cmp++;
        if (pwm !== '0) begin
            n_bad++; $display("FAIL dis_hold: got %h expected 0", pwm);
        end
        rd(5'h10, v);
        n_cmp++;
        if (v !== 32'd768) begin
            n_bad++; $display("FAIL dis_frozen0: got %0d expected 768", v);
        end
        rd(5'h12, v);
        n_cmp++;
        if (v !== 32'd1024) begin
            n_bad++; $display("FAIL dis_frozen2: got %0d expected 1024", v);
        end
        wr(5'd1, 32'd1);
        n_cmp++;
        if (pwm[0] !== 1'b0) begin
            n_bad++; $display("FAIL en_first_cycle: got %0b expected 0", pwm[0]);
        end
        run = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (!pwm[0]) break;
            run++;
        end
        n_cmp++;
        if (run != 768) begin
            n_bad++; $display("FAIL en_restart_run: got %0d expected 768", run);
        end
        $display("test_disable done run=%0d", run);
    endtask

    task automatic test_reset_mid;
        logic [31:0] v;
        logic [4:0] al [7] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'h10, 5'h12, 5'h14};
        wr(5'd2, 32'd1);
        wr(5'h14, 32'd3);
        repeat (300) @(negedge clk);
        n_cmp++;
        if (pwm[2] !== 1'b1) begin
            n_bad++; $display("FAIL rstm_pre: got %0b expected 1", pwm[2]);
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (pwm !== '0) begin
            n_bad++; $display("FAIL rstm_pwm: got %h expected 0", pwm);
        end
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            rd(al[i], v);
            n_cmp++;
            if (v !== 32'd0) begin
                n_bad++; $display("FAIL rstm_reg[%0d]: got %0d expected 0", al[i], v);
            end
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b0;
        test_reset();
        test_basic();
        test_extremes();
        test_midperiod();
`ifdef PWM_FADE_EN
        test_fade();
`endif
        test_boundary_update();
        test_disable();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end
endmodule
